// File: rtl/linear_layer_start_sync_fifo.sv
// Shift-register FIFO carrying start tokens between linear-layer stages.
// All flags are registered from the next occupancy value; error flags are sticky.
module linear_layer_start_sync_fifo #(
  parameter int DATA_WIDTH   = 1,
  parameter int ADDR_WIDTH   = 1,
  parameter int DEPTH        = 2,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic                  if_almost_full,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam int              CNT_W   = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_n_q, empty_n_q, afull_q, ovf_q, unf_q;
  logic                  wr_req, rd_req, push, pop;

  assign wr_req = if_write & if_write_ce;
  assign rd_req = if_read  & if_read_ce;
  // A write at full is refused even when a read frees a slot in the same cycle.
  assign push   = wr_req & full_n_q;
  assign pop    = rd_req & empty_n_q;

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all sequential state.
    if (reset) begin
      count_q   <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      full_n_q  <= (count_d < DEPTH_C);
      empty_n_q <= (count_d != '0);
      afull_q   <= (count_d >= AFULL_C);
      ovf_q     <= ovf_q | (wr_req & ~full_n_q);
      unf_q     <= unf_q | (rd_req & ~empty_n_q);
    end
  end

  // NOTE: storage is deliberately not reset; clearing count alone discards the entries.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  // Oldest entry sits at index count-1; index 0 is presented when empty.
  always_comb begin
    if_dout = mem_q[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (count_q == CNT_W'(i + 1)) begin
        if_dout = mem_q[i];
      end
    end
  end

  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = count_q;
  assign if_almost_full    = afull_q;
  assign err_overflow      = ovf_q;
  assign err_underflow     = unf_q;

endmodule

// File: tb/tb_linear_layer_start_sync_fifo.sv
// Scoreboard bench for linear_layer_start_sync_fifo (DEPTH=2, DATA_WIDTH=8).
// The driver queues hand-computed post-edge expectations; a negedge monitor checks them.
module tb_linear_layer_start_sync_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       if_write_ce, if_write, if_read_ce, if_read;
  logic [7:0] if_din, if_dout;
  logic       if_full_n, if_empty_n, if_almost_full, err_overflow, err_underflow;
  logic [1:0] if_num_data_valid;

  linear_layer_start_sync_fifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2), .AFULL_THRESH(1)
  ) dut (
    .clk(clk), .reset(reset),
    .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
    .if_full_n(if_full_n),
    .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout),
    .if_empty_n(if_empty_n), .if_num_data_valid(if_num_data_valid),
    .if_almost_full(if_almost_full),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         chk_dout;
    logic [7:0] dout;
    logic [1:0] cnt;
    logic       full_n, empty_n, afull, ovf, unf;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input string nm, input bit cd, input logic [7:0] d,
                              input logic [1:0] c, input logic fn, input logic en,
                              input logic af, input logic ov, input logic un);
    exp_t e;
    e.name = nm; e.chk_dout = cd; e.dout = d; e.cnt = c;
    e.full_n = fn; e.empty_n = en; e.afull = af; e.ovf = ov; e.unf = un;
    return e;
  endfunction

  // One clock of stimulus, then the expected post-edge state goes to the scoreboard.
  task automatic drive(input bit rst, input bit wr, input bit wce, input logic [7:0] din,
                       input bit rd, input bit rce, input exp_t e);
    @(negedge clk);
    reset = rst; if_write = wr; if_write_ce = wce; if_din = din;
    if_read = rd; if_read_ce = rce;
    @(posedge clk);
    #1;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are registered or storage-derived, so negedge sampling is stable.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.name, ".count"},   32'(if_num_data_valid), 32'(e.cnt));
      check({e.name, ".full_n"},  32'(if_full_n),         32'(e.full_n));
      check({e.name, ".empty_n"}, 32'(if_empty_n),        32'(e.empty_n));
      check({e.name, ".afull"},   32'(if_almost_full),    32'(e.afull));
      check({e.name, ".ovf"},     32'(err_overflow),      32'(e.ovf));
      check({e.name, ".unf"},     32'(err_underflow),     32'(e.unf));
      if (e.chk_dout) check({e.name, ".dout"}, 32'(if_dout), 32'(e.dout));
    end
  end

  initial begin
    reset = 1'b1; if_write = 1'b0; if_write_ce = 1'b0; if_din = '0;
    if_read = 1'b0; if_read_ce = 1'b0;

    // Reset for two cycles while a write is requested.
    drive(1, 1, 1, 8'h55, 0, 0, mk("rst0", 0, 8'h00, 2'd0, 1, 0, 0, 0, 0));
    drive(1, 1, 1, 8'h55, 0, 0, mk("rst1", 0, 8'h00, 2'd0, 1, 0, 0, 0, 0));

    // Write-enable low does nothing.
    drive(0, 1, 0, 8'h77, 0, 0, mk("wce0", 0, 8'h00, 2'd0, 1, 0, 0, 0, 0));

    // Fill: almost_full from count 1, full after second write, dout stays oldest.
    drive(0, 1, 1, 8'hA1, 0, 0, mk("wrA1", 1, 8'hA1, 2'd1, 1, 1, 1, 0, 0));
    drive(0, 1, 1, 8'hB2, 0, 0, mk("wrB2", 1, 8'hA1, 2'd2, 0, 1, 1, 0, 0));

    // Drain.
    drive(0, 0, 0, 8'h00, 1, 1, mk("rd1", 1, 8'hB2, 2'd1, 1, 1, 1, 0, 0));
    drive(0, 0, 0, 8'h00, 1, 1, mk("rd2", 0, 8'h00, 2'd0, 1, 0, 0, 0, 0));

    // Simultaneous push/pop at count 1.
    drive(0, 1, 1, 8'hA1, 0, 0, mk("pp_wr", 1, 8'hA1, 2'd1, 1, 1, 1, 0, 0));
    drive(0, 1, 1, 8'hC3, 1, 1, mk("pp_C3", 1, 8'hC3, 2'd1, 1, 1, 1, 0, 0));

    // Reset mid-operation with a write pending discards the queue.
    drive(1, 1, 1, 8'h99, 1, 1, mk("rst_mid", 0, 8'h00, 2'd0, 1, 0, 0, 0, 0));

    // Write+read at full: pop happens, write dropped, overflow sticky.
    drive(0, 1, 1, 8'hA1, 0, 0, mk("of_A1", 1, 8'hA1, 2'd1, 1, 1, 1, 0, 0));
    drive(0, 1, 1, 8'hB2, 0, 0, mk("of_B2", 1, 8'hA1, 2'd2, 0, 1, 1, 0, 0));
    drive(0, 1, 1, 8'hD4, 1, 1, mk("of_D4", 1, 8'hB2, 2'd1, 1, 1, 1, 1, 0));
    drive(0, 0, 0, 8'h00, 0, 0, mk("of_idle", 1, 8'hB2, 2'd1, 1, 1, 1, 1, 0));
    drive(0, 0, 0, 8'h00, 1, 1, mk("of_rd", 0, 8'h00, 2'd0, 1, 0, 0, 1, 0));
    drive(1, 0, 0, 8'h00, 0, 0, mk("of_rst", 0, 8'h00, 2'd0, 1, 0, 0, 0, 0));

    // Read at empty: underflow sets and sticks, count stays 0.
    drive(0, 0, 0, 8'h00, 1, 1, mk("uf_rd", 0, 8'h00, 2'd0, 1, 0, 0, 0, 1));
    drive(0, 0, 0, 8'h00, 0, 0, mk("uf_idle", 0, 8'h00, 2'd0, 1, 0, 0, 0, 1));
    drive(1, 0, 0, 8'h00, 0, 0, mk("uf_rst", 0, 8'h00, 2'd0, 1, 0, 0, 0, 0));
    drive(0, 0, 0, 8'h00, 1, 0, mk("uf_rce0", 0, 8'h00, 2'd0, 1, 0, 0, 0, 0));

    // Write+read at empty: push happens, read counts as underflow, no bypass.
    drive(0, 1, 1, 8'hE5, 1, 1, mk("ew_E5", 1, 8'hE5, 2'd1, 1, 1, 1, 0, 1));

    drive(0, 0, 0, 8'h00, 0, 0, mk("final", 1, 8'hE5, 2'd1, 1, 1, 1, 0, 1));

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
